// File: rtl/bcd_countdown_timer.sv
// N-digit BCD countdown timer with pause/resume, saturating bonus add and
// sticky/pulsed expiry flags. Count value drives one 7-segment decoder per nibble.
//
// state     | meaning
// ----------+-------------------------------------------------------------
// S_IDLE    | after reset, waits for reconfig only
// S_PAUSE   | value loaded, not counting; bonus adds still honoured
// S_RUN     | counting down one unit per tick
// S_EXPIRED | count reached zero; holds 0 until reconfig or reset
module bcd_countdown_timer #(
    parameter int          DIGITS  = 2,
    parameter logic [15:0] RELOAD0 = 16'h0060,
    parameter logic [15:0] RELOAD1 = 16'h0045,
    parameter logic [15:0] RELOAD2 = 16'h0030,
    parameter logic [15:0] RELOAD3 = 16'h0015
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  reconfig_i,
    input  logic                  enable_i,
    input  logic                  tick_i,
    input  logic [1:0]            diff_i,
    input  logic                  add_en_i,
    input  logic [3:0]            add_val_i,
    output logic [DIGITS*4-1:0]   count_o,
    output logic                  timeout_o,
    output logic                  expire_pulse_o,
    output logic                  running_o
);

    localparam int W = DIGITS * 4;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_PAUSE   = 2'd1,
        S_RUN     = 2'd2,
        S_EXPIRED = 2'd3
    } state_t;

    state_t         state_q, state_d;
    logic [W-1:0]   count_q, count_d;
    logic           timeout_q, timeout_d;
    logic           pulse_q, pulse_d;
    logic           running_q, running_d;
    logic [W-1:0]   run_val;

    function automatic logic [W-1:0] all_nines();
        logic [W-1:0] res;
        res = '0;
        for (int i = 0; i < DIGITS; i++) begin
            res[i*4 +: 4] = 4'd9;
        end
        return res;
    endfunction

    // Decimal add into the least-significant digit, ripple carry upward;
    // a carry out of the top digit saturates the whole value to all-9s.
    function automatic logic [W-1:0] bcd_add(input logic [W-1:0] v, input logic [3:0] a);
        logic [W-1:0] res;
        logic [4:0]   s;
        logic         carry;
        logic [3:0]   amt;
        amt   = (a > 4'd9) ? 4'd9 : a;
        carry = 1'b0;
        res   = '0;
        for (int i = 0; i < DIGITS; i++) begin
            s = {1'b0, v[i*4 +: 4]} + {4'b0000, carry};
            if (i == 0) begin
                s = s + {1'b0, amt};
            end
            if (s > 5'd9) begin
                s     = s - 5'd10;
                carry = 1'b1;
            end else begin
                carry = 1'b0;
            end
            res[i*4 +: 4] = s[3:0];
        end
        if (carry) begin
            res = all_nines();
        end
        return res;
    endfunction

    // Decimal subtract one with borrow; never called on zero.
    function automatic logic [W-1:0] bcd_dec(input logic [W-1:0] v);
        logic [W-1:0] res;
        logic [3:0]   nib;
        logic         borrow;
        borrow = 1'b1;
        res    = '0;
        for (int i = 0; i < DIGITS; i++) begin
            nib = v[i*4 +: 4];
            if (borrow) begin
                if (nib == 4'd0) begin
                    nib = 4'd9;
                end else begin
                    nib    = nib - 4'd1;
                    borrow = 1'b0;
                end
            end
            res[i*4 +: 4] = nib;
        end
        return res;
    endfunction

    function automatic logic [W-1:0] reload_sel(input logic [1:0] d);
        logic [W-1:0] res;
        case (d)
            2'd0:    res = RELOAD0[W-1:0];
            2'd1:    res = RELOAD1[W-1:0];
            2'd2:    res = RELOAD2[W-1:0];
            default: res = RELOAD3[W-1:0];
        endcase
        return res;
    endfunction

    // State and registered outputs.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= S_IDLE;
            count_q   <= '0;
            timeout_q <= 1'b0;
            pulse_q   <= 1'b0;
            running_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            timeout_q <= timeout_d;
            pulse_q   <= pulse_d;
            running_q <= running_d;
        end
    end

    // Next-state and next-output logic; reconfig overrides every state.
    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        timeout_d = timeout_q;
        pulse_d   = 1'b0;
        run_val   = count_q;

        if (reconfig_i) begin
            count_d   = reload_sel(diff_i);
            timeout_d = 1'b0;
            state_d   = S_PAUSE;
        end else begin
            case (state_q)
                S_IDLE: begin
                end
                S_PAUSE: begin
                    if (add_en_i) begin
                        run_val = bcd_add(count_q, add_val_i);
                    end
                    count_d = run_val;
                    if (enable_i) begin
                        if (run_val == '0) begin
                            state_d   = S_EXPIRED;
                            timeout_d = 1'b1;
                            pulse_d   = 1'b1;
                        end else begin
                            state_d = S_RUN;
                        end
                    end
                end
                S_RUN: begin
                    if (!enable_i) begin
                        state_d = S_PAUSE;
                    end else begin
                        if (add_en_i) begin
                            run_val = bcd_add(run_val, add_val_i);
                        end
                        if (tick_i) begin
                            run_val = bcd_dec(run_val);
                        end
                        count_d = run_val;
                        if (run_val == '0) begin
                            state_d   = S_EXPIRED;
                            timeout_d = 1'b1;
                            pulse_d   = 1'b1;
                        end
                    end
                end
                S_EXPIRED: begin
                    count_d = '0;
                end
                default: begin
                    state_d = S_IDLE;
                    count_d = '0;
                end
            endcase
        end

        running_d = (state_d == S_RUN);
    end

    assign count_o        = count_q;
    assign timeout_o      = timeout_q;
    assign expire_pulse_o = pulse_q;
    assign running_o      = running_q;

endmodule

// File: tb/tb_bcd_countdown_timer.sv
// Bench for bcd_countdown_timer: directed vector table, hand-written corner
// sequences (async reset, 3-digit borrow), then random stimulus against a
// decimal-integer reference model.
module tb_bcd_countdown_timer;

    logic        clk;
    logic        rst_n;
    logic        reconfig;
    logic        enable;
    logic        tick;
    logic [1:0]  diff;
    logic        add_en;
    logic [3:0]  add_val;
    logic [7:0]  count;
    logic        timeout;
    logic        expire_pulse;
    logic        running;
    logic [11:0] count3;
    logic        timeout3;
    logic        expire_pulse3;
    logic        running3;

    int n_chk = 0;
    int n_err = 0;

    bcd_countdown_timer u_dut (
        .clk_i          (clk),
        .rst_ni         (rst_n),
        .reconfig_i     (reconfig),
        .enable_i       (enable),
        .tick_i         (tick),
        .diff_i         (diff),
        .add_en_i       (add_en),
        .add_val_i      (add_val),
        .count_o        (count),
        .timeout_o      (timeout),
        .expire_pulse_o (expire_pulse),
        .running_o      (running)
    );

    bcd_countdown_timer #(.DIGITS(3), .RELOAD0(16'h0100)) u_dut3 (
        .clk_i          (clk),
        .rst_ni         (rst_n),
        .reconfig_i     (reconfig),
        .enable_i       (enable),
        .tick_i         (tick),
        .diff_i         (diff),
        .add_en_i       (add_en),
        .add_val_i      (add_val),
        .count_o        (count3),
        .timeout_o      (timeout3),
        .expire_pulse_o (expire_pulse3),
        .running_o      (running3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit       rc;
        bit       en;
        bit       tk;
        bit [1:0] df;
        bit       ae;
        bit [3:0] av;
        int       cnt;
        bit       to;
        bit       pu;
        bit       run;
    } vec_t;

    vec_t vecs[$];

    function automatic void v(bit rc, bit en, bit tk, bit [1:0] df, bit ae, bit [3:0] av,
                              int cnt, bit to, bit pu, bit run);
        vec_t x;
        x.rc = rc; x.en = en; x.tk = tk; x.df = df; x.ae = ae; x.av = av;
        x.cnt = cnt; x.to = to; x.pu = pu; x.run = run;
        vecs.push_back(x);
    endfunction

    function automatic logic [7:0] to_bcd(int n);
        return {4'(n / 10), 4'(n % 10)};
    endfunction

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Reference model: plain decimal arithmetic, not BCD nibbles.
    typedef enum {M_IDLE, M_PAUSE, M_RUN, M_EXP} mstate_t;
    mstate_t m_st;
    int      m_cnt;
    bit      m_to;
    bit      m_pu;

    function automatic int m_reload(bit [1:0] d);
        case (d)
            2'd0: return 60;
            2'd1: return 45;
            2'd2: return 30;
            default: return 15;
        endcase
    endfunction

    function automatic int m_add(int c, int a);
        int s;
        s = c + ((a > 9) ? 9 : a);
        return (s > 99) ? 99 : s;
    endfunction

    task automatic m_reset();
        m_st = M_IDLE; m_cnt = 0; m_to = 0; m_pu = 0;
    endtask

    task automatic m_step(bit rc, bit en, bit tk, bit [1:0] df, bit ae, int av);
        m_pu = 0;
        if (rc) begin
            m_cnt = m_reload(df); m_to = 0; m_st = M_PAUSE;
        end else begin
            case (m_st)
                M_PAUSE: begin
                    if (ae) m_cnt = m_add(m_cnt, av);
                    if (en) begin
                        if (m_cnt == 0) begin m_st = M_EXP; m_to = 1; m_pu = 1; end
                        else m_st = M_RUN;
                    end
                end
                M_RUN: begin
                    if (!en) m_st = M_PAUSE;
                    else begin
                        if (ae) m_cnt = m_add(m_cnt, av);
                        if (tk) m_cnt = m_cnt - 1;
                        if (m_cnt == 0) begin m_st = M_EXP; m_to = 1; m_pu = 1; end
                    end
                end
                default: ;
            endcase
        end
    endtask

    task automatic drive(bit rc, bit en, bit tk, bit [1:0] df, bit ae, bit [3:0] av);
        reconfig = rc; enable = en; tick = tk; diff = df; add_en = ae; add_val = av;
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        drive(0, 0, 0, 0, 0, 0);
        cyc();
        cyc();
        rst_n = 1'b1;
        cyc();
    endtask

    initial begin
        rst_n = 1'b0;
        drive(0, 0, 0, 0, 0, 0);

        // Directed table: reset-relative sequence through the main scenarios.
        v(1,0,0,2,0,0, 30,0,0,0);
        v(0,1,0,0,0,0, 30,0,0,1);
        v(0,1,1,0,0,0, 29,0,0,1);
        v(0,1,1,0,0,0, 28,0,0,1);
        v(0,1,1,0,0,0, 27,0,0,1);
        for (int i = 1; i <= 7; i++) v(0,1,0,0,1,9, 27 + 9*i,0,0,1);
        v(0,1,0,0,1,7, 97,0,0,1);
        v(0,1,0,0,1,5, 99,0,0,1);
        v(0,1,0,0,1,15, 99,0,0,1);
        v(1,1,1,2,1,3, 30,0,0,0);
        v(0,0,0,0,1,8, 38,0,0,0);
        v(0,0,0,0,1,14, 47,0,0,0);
        v(0,1,0,0,0,0, 47,0,0,1);
        v(0,1,0,0,1,12, 56,0,0,1);
        v(1,0,0,2,0,0, 30,0,0,0);
        v(0,1,0,0,0,0, 30,0,0,1);
        for (int i = 1; i <= 10; i++) v(0,1,1,0,0,0, 30 - i,0,0,1);
        v(0,0,1,0,0,0, 20,0,0,0);
        v(0,0,1,0,0,0, 20,0,0,0);
        v(0,0,1,0,0,0, 20,0,0,0);
        v(0,1,0,0,0,0, 20,0,0,1);
        v(0,1,1,0,0,0, 19,0,0,1);
        for (int i = 1; i <= 14; i++) v(0,1,1,0,0,0, 19 - i,0,0,1);
        v(0,1,1,0,1,3, 7,0,0,1);
        v(0,1,0,0,1,3, 10,0,0,1);
        v(0,1,1,0,0,0, 9,0,0,1);
        v(1,0,0,3,0,0, 15,0,0,0);
        v(0,1,0,0,0,0, 15,0,0,1);
        for (int i = 1; i <= 14; i++) v(0,1,1,0,0,0, 15 - i,0,0,1);
        v(0,1,1,0,0,0, 0,1,1,0);
        v(0,1,1,0,1,5, 0,1,0,0);
        v(0,1,1,0,0,0, 0,1,0,0);
        v(0,0,0,0,1,9, 0,1,0,0);
        v(1,1,1,1,1,2, 45,0,0,0);

        do_reset();
        chk("reset_count",   16'(count),        16'h0);
        chk("reset_timeout", 16'(timeout),      16'h0);
        chk("reset_pulse",   16'(expire_pulse), 16'h0);
        chk("reset_running", 16'(running),      16'h0);

        // IDLE ignores everything except reconfig.
        drive(0, 1, 1, 0, 1, 5);
        cyc();
        cyc();
        chk("idle_ignore", {7'd0, count, timeout, running}, 16'h0);

        foreach (vecs[i]) begin
            drive(vecs[i].rc, vecs[i].en, vecs[i].tk, vecs[i].df, vecs[i].ae, vecs[i].av);
            cyc();
            chk($sformatf("vec%0d", i),
                {5'd0, count, timeout, expire_pulse, running},
                {5'd0, to_bcd(vecs[i].cnt), vecs[i].to, vecs[i].pu, vecs[i].run});
        end

        // Asynchronous reset mid-run at 12.
        drive(1, 0, 0, 3, 0, 0); cyc();
        drive(0, 1, 0, 0, 0, 0); cyc();
        drive(0, 1, 1, 0, 0, 0); cyc(); cyc(); cyc();
        chk("pre_reset_12", 16'(count), 16'h12);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_count",   16'(count),   16'h0);
        chk("async_rst_timeout", 16'(timeout), 16'h0);
        chk("async_rst_running", 16'(running), 16'h0);
        @(negedge clk);
        rst_n = 1'b1;
        cyc(); cyc();
        chk("post_rst_idle", {7'd0, count, running}, 16'h0);
        drive(1, 1, 1, 0, 0, 0); cyc();
        chk("reload_60", {7'd0, count, running}, {7'd0, 8'h60, 1'b0});

        // Three-digit borrow chain on the second instance: 100 -> 099.
        drive(1, 0, 0, 0, 0, 0); cyc();
        chk("dut3_load", 16'(count3), 16'h100);
        drive(0, 1, 0, 0, 0, 0); cyc();
        drive(0, 1, 1, 0, 0, 0); cyc();
        chk("dut3_borrow", 16'(count3), 16'h099);
        chk("dut3_running", 16'(running3), 16'h1);

        // Random phase against the reference model.
        do_reset();
        m_reset();
        for (int n = 0; n < 3000; n++) begin
            bit       rc, en, tk, ae;
            bit [1:0] df;
            bit [3:0] av;
            if ($urandom_range(0, 299) == 0) begin
                rst_n = 1'b0;
                #2;
                rst_n = 1'b1;
                m_reset();
                chk($sformatf("rnd_rst%0d", n), {5'd0, count, timeout, expire_pulse, running}, 16'h0);
            end
            rc = ($urandom_range(0, 24) == 0);
            en = ($urandom_range(0, 9) < 8);
            tk = $urandom_range(0, 1);
            ae = ($urandom_range(0, 7) == 0);
            df = 2'($urandom_range(0, 3));
            av = 4'($urandom_range(0, 15));
            drive(rc, en, tk, df, ae, av);
            cyc();
            m_step(rc, en, tk, df, ae, int'(av));
            chk($sformatf("rnd%0d", n),
                {5'd0, count, timeout, expire_pulse, running},
                {5'd0, to_bcd(m_cnt), m_to, m_pu, (m_st == M_RUN)});
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/bcd_countdown_timer.md
# bcd_countdown_timer

Parametrised N-digit BCD countdown timer: the successor to the fixed two-digit game timer. It loads a per-difficulty reload value, counts down one unit per external tick, supports pause/resume and saturating bonus-time add, and flags expiry with a sticky level and a one-cycle pulse. It sits between the game controller (reconfig/enable/diff/bonus) and the seven-segment decoders (one decoder per `count` nibble), with `tick` driven by the existing millisecond/second pulse timer.

## Interface
- `DIGITS`, 2: number of BCD digits, legal 1–4; `count` width is `DIGITS*4`.
- `RELOAD0`, 16'h0060: BCD reload value for `diff`=0; low `DIGITS*4` bits used.
- `RELOAD1`, 16'h0045: reload value for `diff`=1.
- `RELOAD2`, 16'h0030: reload value for `diff`=2.
- `RELOAD3`, 16'h0015: reload value for `diff`=3.

- `clk` in 1: single clock; all state changes on the rising edge.
- `rst` in 1: one clock; reset is asynchronous and active-low.
- `reconfig` in 1: load reload value selected by `diff`; highest priority.
- `enable` in 1: level; 1 = run, 0 = pause.
- `tick` in 1: one-cycle decrement strobe.
- `diff` in 2: difficulty select; sampled only when `reconfig`=1.
- `add_en` in 1: one-cycle bonus-add strobe.
- `add_val` in 4: bonus amount, added to the least-significant digit; values >9 clamp to 9.
- `count` out `DIGITS*4`: current BCD value, MS digit in the top nibble.
- `timeout` out 1: sticky expiry flag.
- `expire_pulse` out 1: one-cycle pulse on expiry.
- `running` out 1: high in RUN.

## Operation
- States: IDLE, PAUSE, RUN, EXPIRED.
- Reset (`rst`=0, asynchronous): state IDLE, `count`=0, `timeout`=0, `expire_pulse`=0, `running`=0.
- `reconfig`=1 in any state: `count` loads RELOADn[`diff`]; `timeout` clears; next state PAUSE. `tick`, `add_en` and `enable` are ignored that cycle.
- IDLE: waits only for `reconfig`. All other inputs are ignored.
- PAUSE:
  - `enable`=1 and `count`≠0: go to RUN.
  - `enable`=1 and `count`=0: go to EXPIRED, raise `expire_pulse`.
  - `tick` is ignored; `add_en` is honoured.
- RUN:
  - `enable`=0: go to PAUSE; any `tick` that cycle is ignored.
  - Otherwise, per cycle: if `add_en`, apply the add; then if `tick`, decrement by 1.
- Add rule: BCD add of clamped `add_val` with decimal carry across all digits. If the result exceeds all-9s (e.g. 99 for `DIGITS`=2), `count` saturates to all-9s.
- Decrement rule: BCD subtract 1 with borrow (e.g. 40→39, 100→099).
- Decrement from 0 is impossible by construction. Expiry is checked on the post-update value.
- Post-update `count`=0 in RUN: go to EXPIRED; `timeout`=1; `expire_pulse`=1 for exactly one cycle.
- EXPIRED: `count` holds 0. `tick`, `add_en` and `enable` are ignored. `timeout` stays 1 until `reconfig` or reset.
- Out-of-range BCD nibbles cannot arise internally. A parameter containing a nibble >9 is an illegal configuration.

## Timing
- All outputs are registered.
- `count`, `timeout`, `running` and `expire_pulse` reflect the edge on which the causing input was sampled, with no extra latency.
- `running` equals (state==RUN), registered.
- `expire_pulse` is high in the first cycle of EXPIRED only.
- Back-to-back `tick` on consecutive cycles decrements on each cycle.
- Asserting `rst` mid-count aborts immediately, without waiting for a clock edge. After deassertion the block stays in IDLE until `reconfig`.
- Simultaneous events:
  - `tick`+`add_en`: add first, then decrement. Example: 05 + 3 → 07.
  - `reconfig`+anything: reconfig wins.
  - `enable` falling + `tick`: no decrement.

## Test plan
- Reset, then `reconfig` with `diff`=2, then `enable`=1, then 3 ticks → `count` 30→29→28→27, `running`=1, `timeout`=0.
- `diff`=3 (15), run 15 ticks → on the 15th tick `count`=00, `timeout`=1, `expire_pulse` high for exactly 1 cycle, `running`=0. Further ticks and adds leave `count`=00.
- Borrow chain with `DIGITS`=3 and RELOAD0=16'h0100 → one tick gives 099. With `DIGITS`=2, count 10 plus tick gives 09.
- Add with saturation: count 97, `add_en` with `add_val`=5 → 99. Count 38, `add_val`=14 (clamped to 9) → 47. Count 05, `add_en` with `add_val`=3 plus `tick` in the same cycle → 07.
- Pause: at count 20, drop `enable` in the same cycle as `tick` → count stays 20 and `running`=0. Ticks during PAUSE have no effect. Re-raise `enable`, then 1 tick → 19.
- Asynchronous reset mid-run at count 12 → `count`=0, `timeout`=0, state IDLE immediately. Then `reconfig` with `diff`=0 → 60 in PAUSE. Also: `reconfig` during EXPIRED clears `timeout` and reloads.
